// File: rtl/srv_imem_line_fill.sv
// srv_imem_line_fill: fetches a 4-word instruction line from backing memory,
// with a one-line buffer that answers repeat requests for the last delivered line.
module srv_imem_line_fill #(
  parameter bit BUF_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ext_req_i,
  input  logic [31:0]  ext_addr_i,
  output logic         ext_rsp_o,
  output logic [127:0] ext_data_o,
  input  logic         flush_i,
  output logic         busy_o,
  output logic         mem_req_o,
  output logic [31:0]  mem_addr_o,
  input  logic         mem_gnt_i,
  input  logic         mem_rvalid_i,
  input  logic [31:0]  mem_rdata_i
);
  typedef enum logic [1:0] {IDLE, FETCH, RESP} state_t;
  state_t          state_q, state_d;
  logic [31:0]     line_addr_q, line_addr_d, buf_addr_q, buf_addr_d, req_line;
  logic [2:0]      issue_q, issue_d, ret_q, ret_d;
  logic            buf_valid_q, buf_valid_d, flushed_q, flushed_d, hit, ret_ok;
  logic [3:0][31:0] line_q;

  assign req_line   = ext_addr_i & ~32'd3;
  assign hit        = BUF_EN && buf_valid_q && !flush_i && req_line == buf_addr_q;
  assign mem_req_o  = state_q == FETCH && issue_q < 3'd4;
  assign mem_addr_o = mem_req_o ? line_addr_q + 32'(issue_q) : '0;
  // Only rvalids matching an outstanding read are accepted.
  assign ret_ok     = state_q == FETCH && mem_rvalid_i && ret_q < issue_q;
  assign ext_rsp_o  = state_q == RESP;
  assign ext_data_o = line_q;
  assign busy_o     = state_q != IDLE;

  always_comb begin
    state_d     = state_q;
    line_addr_d = line_addr_q;
    buf_addr_d  = buf_addr_q;
    buf_valid_d = buf_valid_q;
    flushed_d   = flushed_q | flush_i;
    issue_d     = issue_q + {2'b0, mem_req_o && mem_gnt_i};
    ret_d       = ret_q + {2'b0, ret_ok};
    case (state_q)
      IDLE: if (ext_req_i) begin
        line_addr_d = req_line;
        state_d     = hit ? RESP : FETCH;
        issue_d     = hit ? issue_q : '0;
        ret_d       = hit ? ret_q : '0;
        flushed_d   = 1'b0;
      end
      FETCH: if (ret_ok && ret_q == 3'd3) begin
        state_d     = RESP;
        buf_valid_d = !flushed_d;
        buf_addr_d  = flushed_d ? buf_addr_q : line_addr_q;
      end
      default: state_d = IDLE;
    endcase
    if (flush_i) buf_valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      line_addr_q <= '0;
      buf_addr_q  <= '0;
      buf_valid_q <= 1'b0;
      flushed_q   <= 1'b0;
      issue_q     <= '0;
      ret_q       <= '0;
      line_q      <= '0;
    end else begin
      state_q     <= state_d;
      line_addr_q <= line_addr_d;
      buf_addr_q  <= buf_addr_d;
      buf_valid_q <= buf_valid_d;
      flushed_q   <= flushed_d;
      issue_q     <= issue_d;
      ret_q       <= ret_d;
      if (ret_ok) line_q[ret_q[1:0]] <= mem_rdata_i;
    end
  end
endmodule

// File: tb/tb_srv_imem_line_fill.sv
// tb_srv_imem_line_fill: table-driven and randomized checks of the line-fill responder
// against a line-buffer reference model and a pipelined memory model.
module tb_srv_imem_line_fill;
  logic clk = 0, rst_n = 0, ext_req_i = 0, flush_i = 0;
  logic [31:0] ext_addr_i = 0;
  logic ext_rsp_o, busy_o, mem_req_o, mem_gnt_i = 0, mem_rvalid_i = 0;
  logic [127:0] ext_data_o;
  logic [31:0] mem_addr_o, mem_rdata_i = 0;
  logic nb_rsp, nb_busy, nb_req, nb_rvalid = 0;
  logic [127:0] nb_data;
  logic [31:0] nb_addr, nb_rdata = 0;

  always #5 clk = ~clk;

  srv_imem_line_fill #(.BUF_EN(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .ext_req_i(ext_req_i), .ext_addr_i(ext_addr_i),
    .ext_rsp_o(ext_rsp_o), .ext_data_o(ext_data_o), .flush_i(flush_i), .busy_o(busy_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i));

  srv_imem_line_fill #(.BUF_EN(1'b0)) u_nb (
    .clk(clk), .rst_n(rst_n), .ext_req_i(ext_req_i), .ext_addr_i(ext_addr_i),
    .ext_rsp_o(nb_rsp), .ext_data_o(nb_data), .flush_i(flush_i), .busy_o(nb_busy),
    .mem_req_o(nb_req), .mem_addr_o(nb_addr), .mem_gnt_i(1'b1),
    .mem_rvalid_i(nb_rvalid), .mem_rdata_i(nb_rdata));

  int errors = 0, checks = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] memf(input logic [31:0] a);
    return 32'hA000_0000 + a;
  endfunction

  // Pipelined memory: in-order read queue with per-read extra latency.
  logic [31:0] qa[$], granted[$];
  int qd[$];
  int gmode = 0, sc = 0, ncyc = 0, rv_n = 0, last_rv = 0, junk_cyc = -1;
  bit prev_stall = 0, nb_pend = 0;
  logic [31:0] prev_addr = 0, nb_paddr = 0;

  always @(posedge clk) ncyc++;

  always @(negedge clk) begin
    if (prev_stall && rst_n) check("addr_hold", {mem_req_o, mem_addr_o}, {1'b1, prev_addr});
    mem_rvalid_i = 0;
    mem_rdata_i = 0;
    if (qa.size() > 0 && qd[0] == 0) begin
      mem_rvalid_i = 1;
      mem_rdata_i = memf(qa[0]);
      void'(qa.pop_front());
      void'(qd.pop_front());
      rv_n++;
      if (rv_n == 4) last_rv = ncyc;
    end else if (qa.size() > 0) qd[0] = qd[0] - 1;
    else if (ncyc == junk_cyc) begin
      mem_rvalid_i = 1;
      mem_rdata_i = 32'hDEAD_BEEF;
    end
    if (gmode == 1) begin
      mem_gnt_i = mem_req_o && sc == 2;
      if (mem_req_o) sc = (sc == 2) ? 0 : sc + 1;
    end else mem_gnt_i = (gmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    if (rst_n && mem_req_o && mem_gnt_i) begin
      qa.push_back(mem_addr_o);
      qd.push_back(gmode == 2 ? int'($urandom_range(0, 2)) : 0);
      granted.push_back(mem_addr_o);
    end
    prev_stall = rst_n && mem_req_o && !mem_gnt_i;
    prev_addr = mem_addr_o;
    nb_rvalid = nb_pend;
    nb_rdata = memf(nb_paddr);
    nb_pend = rst_n && nb_req;
    nb_paddr = nb_addr;
  end

  // Reference: last delivered line is buffered unless a flush hit it.
  bit ref_v = 0;
  logic [31:0] ref_a = 0;

  task automatic txn(input logic [31:0] a, input int fl, input int gm, input bit jk, input int exp_lat);
    logic [31:0] line;
    logic [127:0] exp_d, got = 0, ngot = 0;
    bit hit;
    int t0, first = 0, nfirst = 0, pulses = 0, nreqs = 0, bad_busy = 0;
    line = a & ~32'd3;
    hit = ref_v && ref_a == line && fl != 0;
    exp_d = {memf(line + 3), memf(line + 2), memf(line + 1), memf(line)};
    @(negedge clk);
    check("rsp_idle", {ext_rsp_o, nb_rsp}, 0);
    gmode = gm;
    sc = 0;
    granted.delete();
    rv_n = 0;
    t0 = ncyc;
    junk_cyc = jk ? t0 + 1 : -1;
    ext_req_i = 1;
    ext_addr_i = a;
    flush_i = (fl == 0);
    for (int c = 1; c <= 80 && (first == 0 || nfirst == 0); c++) begin
      @(negedge clk);
      ext_req_i = 0;
      flush_i = (fl == c);
      if (busy_o !== (first == 0)) bad_busy++;
      if (ext_rsp_o) begin
        pulses++;
        if (first == 0) begin first = c; got = ext_data_o; end
      end
      if (nb_req) nreqs++;
      if (nb_rsp && nfirst == 0) begin nfirst = c; ngot = nb_data; end
    end
    check("rsp_lat", first, hit ? 1 : last_rv - t0 + 1);
    if (exp_lat > 0) check("lat_tbl", first, exp_lat);
    check("data", got, exp_d);
    check("pulses", pulses, 1);
    check("grants", granted.size(), hit ? 0 : 4);
    for (int i = 0; i < granted.size() && i < 4; i++) check("gaddr", granted[i], line + i);
    check("busy", bad_busy, 0);
    check("nb_lat", nfirst, 6);
    check("nb_data", ngot, exp_d);
    check("nb_reqs", nreqs, 4);
    if (fl >= 1) ref_v = 0;
    else if (!hit) begin ref_v = 1; ref_a = line; end
  endtask

  typedef struct {
    bit pre_flush;
    logic [31:0] a;
    int fl, gm;
    bit jk;
    int lat;
  } vec_t;
  vec_t tbl[14];
  logic [31:0] addrs[6];

  initial begin
    tbl[0]  = '{0, 32'h104, -1, 0, 0, 6};
    tbl[1]  = '{0, 32'h108, -1, 0, 0, 6};
    tbl[2]  = '{0, 32'h107, -1, 0, 0, 6};
    tbl[3]  = '{0, 32'h107, -1, 0, 0, 1};
    tbl[4]  = '{1, 32'h104, -1, 1, 1, 0};
    tbl[5]  = '{0, 32'h104, -1, 0, 0, 1};
    tbl[6]  = '{1, 32'h104, -1, 0, 0, 6};
    tbl[7]  = '{0, 32'h200, 3, 0, 0, 6};
    tbl[8]  = '{0, 32'h200, -1, 0, 0, 6};
    tbl[9]  = '{0, 32'h200, -1, 0, 0, 1};
    tbl[10] = '{0, 32'h200, 0, 0, 0, 6};
    tbl[11] = '{0, 32'h200, -1, 0, 0, 1};
    tbl[12] = '{0, 32'h200, 1, 0, 0, 1};
    tbl[13] = '{0, 32'h200, -1, 0, 0, 6};
    addrs = '{32'h104, 32'h107, 32'h108, 32'h10B, 32'h200, 32'h3FC};
    repeat (2) @(negedge clk);
    check("rst_rsp", {ext_rsp_o, mem_req_o, busy_o}, 0);
    check("rst_data", ext_data_o, 0);
    check("rst_addr", mem_addr_o, 0);
    rst_n = 1;
    foreach (tbl[i]) begin
      if (tbl[i].pre_flush) begin
        @(negedge clk);
        flush_i = 1;
        @(negedge clk);
        flush_i = 0;
        ref_v = 0;
      end
      txn(tbl[i].a, tbl[i].fl, tbl[i].gm, tbl[i].jk, tbl[i].lat);
    end
    // Reset in the middle of a fetch, after two grants.
    @(negedge clk);
    gmode = 0;
    granted.delete();
    ext_req_i = 1;
    ext_addr_i = 32'h104;
    flush_i = 0;
    @(negedge clk);
    ext_req_i = 0;
    for (int i = 0; i < 20 && granted.size() < 2; i++) @(negedge clk);
    rst_n = 0;
    #1;
    check("rst_mid_ctl", {ext_rsp_o, mem_req_o, busy_o, nb_rsp, nb_req, nb_busy}, 0);
    check("rst_mid_data", ext_data_o, 0);
    check("rst_mid_addr", {mem_addr_o, nb_addr}, 0);
    qa.delete();
    qd.delete();
    nb_pend = 0;
    ref_v = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    txn(32'h104, -1, 0, 0, 6);
    for (int i = 0; i < 120; i++)
      txn(addrs[$urandom_range(0, 5)], ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 2)) : -1,
          2, 1'($urandom_range(0, 1)), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
